reg_writeback_queue: RTL and testbench

// - Write-back stage directly upstream of the 32x32 register file write port.
// - Buffers retired results (rd, value) from execute in a DEPTH-entry FIFO.
// - Drains the FIFO in order as stb/cyc/ack write transactions to the register file.
// - Reports pending writes to rs1/rs2 so decode can stall, or forward data when enabled.

---
 rtl/reg_writeback_queue.sv | 113 +++++++++++
 tb/tb_reg_writeback_queue.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_writeback_queue.sv
// reg_writeback_queue: in-order write-back FIFO draining into the register file, with hazard/forward reporting
// Define WB_FORWARD_EN to drive fwd_rs1_o/fwd_rs2_o from the youngest matching queued entry.
module reg_writeback_queue #(
   parameter int DEPTH = 4
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        wb_valid_i,
   output logic        wb_ready_o,
   input  logic [4:0]  wb_rd_i,
   input  logic [31:0] wb_data_i,
   output logic        stb_write_o,
   output logic        cyc_write_o,
   output logic [4:0]  op_rd_o,
   output logic [31:0] reg_rd_o,
   input  logic        ack_write_i,
   input  logic [4:0]  op_rs1_i,
   input  logic [4:0]  op_rs2_i,
   output logic        pending_rs1_o,
   output logic        pending_rs2_o,
   output logic [31:0] fwd_rs1_o,
   output logic [31:0] fwd_rs2_o,
   output logic        empty_o
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
   typedef enum logic [1:0] {IDLE, WRITE, GAP} state_t;
   state_t        state_q, state_d;
   logic [4:0]    rd_q   [DEPTH];
   logic [31:0]   data_q [DEPTH];
   logic [AW-1:0] head_q, head_d, tail_q, tail_d, idx;
   logic [AW:0]   count_q, count_d;
   logic          push, pop;
   assign wb_ready_o = count_q != FULL;
   assign push = wb_valid_i & wb_ready_o & (wb_rd_i != 5'd0);
   assign pop  = (state_q == WRITE) & ack_write_i;
   // pointer and occupancy update; index-0 results complete the handshake but are dropped
   always_comb begin
      head_d  = head_q + AW'(pop);
      tail_d  = tail_q + AW'(push);
      count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
   end
   // pointers, count and FSM state; reset abandons any write in flight
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         state_q <= IDLE;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         state_q <= state_d;
      end
   end
   // entry storage needs no reset: only slots inside the count window are ever observed
   always_ff @(posedge clk_i) begin
      if (push) begin
         rd_q[tail_q]   <= wb_rd_i;
         data_q[tail_q] <= wb_data_i;
      end
   end
   // write sequencing: GAP drops the strobe for one cycle so the register file can clear its ack
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    state_d = (count_q != '0) ? WRITE : IDLE;
         WRITE:   state_d = ack_write_i ? GAP : WRITE;
         GAP:     state_d = (count_q != '0) ? WRITE : IDLE;
         default: state_d = IDLE;
      endcase
   end
   // bus outputs present the head entry only while a write is in progress
   always_comb begin
      stb_write_o = state_q == WRITE;
      cyc_write_o = stb_write_o;
      op_rd_o     = stb_write_o ? rd_q[head_q] : 5'd0;
      reg_rd_o    = stb_write_o ? data_q[head_q] : 32'd0;
      empty_o     = (count_q == '0) & (state_q == IDLE);
   end
   // hazard scan oldest to youngest so the last match seen is the youngest entry
   always_comb begin
      pending_rs1_o = 1'b0;
      pending_rs2_o = 1'b0;
      idx           = head_q;
`ifdef WB_FORWARD_EN
      fwd_rs1_o     = 32'd0;
      fwd_rs2_o     = 32'd0;
`endif
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + AW'(i);
         if ((AW+1)'(i) < count_q) begin
            if ((op_rs1_i != 5'd0) && (rd_q[idx] == op_rs1_i)) begin
               pending_rs1_o = 1'b1;
`ifdef WB_FORWARD_EN
               fwd_rs1_o     = data_q[idx];
`endif
            end
            if ((op_rs2_i != 5'd0) && (rd_q[idx] == op_rs2_i)) begin
               pending_rs2_o = 1'b1;
`ifdef WB_FORWARD_EN
               fwd_rs2_o     = data_q[idx];
`endif
            end
         end
      end
   end
`ifndef WB_FORWARD_EN
   assign fwd_rs1_o = 32'd0;
   assign fwd_rs2_o = 32'd0;
`endif
endmodule

// File: tb/tb_reg_writeback_queue.sv
// tb_reg_writeback_queue: directed table plus multi-cycle sequences for reg_writeback_queue
module tb_reg_writeback_queue;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        wb_valid_i = 1'b0, wb_ready_o, ack_write_i = 1'b0;
   logic [4:0]  wb_rd_i = 5'd0, op_rs1_i = 5'd0, op_rs2_i = 5'd0, op_rd_o;
   logic [31:0] wb_data_i = 32'd0, reg_rd_o, fwd_rs1_o, fwd_rs2_o;
   logic        stb_write_o, cyc_write_o, pending_rs1_o, pending_rs2_o, empty_o;

   reg_writeback_queue #(.DEPTH(4)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .wb_valid_i(wb_valid_i), .wb_ready_o(wb_ready_o),
      .wb_rd_i(wb_rd_i), .wb_data_i(wb_data_i), .stb_write_o(stb_write_o), .cyc_write_o(cyc_write_o),
      .op_rd_o(op_rd_o), .reg_rd_o(reg_rd_o), .ack_write_i(ack_write_i), .op_rs1_i(op_rs1_i),
      .op_rs2_i(op_rs2_i), .pending_rs1_o(pending_rs1_o), .pending_rs2_o(pending_rs2_o),
      .fwd_rs1_o(fwd_rs1_o), .fwd_rs2_o(fwd_rs2_o), .empty_o(empty_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic v; logic [4:0] rd; logic [31:0] d; logic ack; logic [4:0] rs1, rs2;
      logic rdy, stb; logic [4:0] ord; logic [31:0] odat; logic p1, p2; logic [31:0] f1, f2; logic emp;
   } vec_t;
   typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;

   vec_t tbl[16];
   ent_t src_q[$], exp_q[$];
   int checks = 0, errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   function automatic logic [31:0] fwd_req(input logic [31:0] v);
`ifdef WB_FORWARD_EN
      return v;
`else
      return 32'd0 & v;
`endif
   endfunction

   function automatic vec_t mk(input logic v, input logic [4:0] rd, input logic [31:0] d, input logic ack,
                               input logic [4:0] rs1, input logic [4:0] rs2, input logic rdy, input logic stb,
                               input logic [4:0] ord, input logic [31:0] odat, input logic p1, input logic p2,
                               input logic [31:0] f1, input logic [31:0] f2, input logic emp);
      vec_t r;
      r = '{v, rd, d, ack, rs1, rs2, rdy, stb, ord, odat, p1, p2, f1, f2, emp};
      return r;
   endfunction

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   // pushes src_q and checks each write against exp_q in order; optional ack one cycle after stb
   task automatic run_sb(input string tag, input int budget, input bit delayed, input int nwr);
      bit gap_due = 1'b0, prev_stb = 1'b0, done = 1'b0, pushed, popped;
      int n = 0;
      ent_t e;
      for (int c = 0; c < budget && !done; c++) begin
         wb_valid_i = src_q.size() != 0;
         if (wb_valid_i) begin
            wb_rd_i   = src_q[0].rd;
            wb_data_i = src_q[0].d;
         end
         ack_write_i = stb_write_o & (!delayed | prev_stb);
         #1;
         if (gap_due) chk({tag, "_gap"}, 32'(stb_write_o), 32'd0);
         if (stb_write_o) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL %s_extra_write actual rd=%0d required none", tag, op_rd_o);
            end else begin
               chk({tag, "_rd"}, 32'(op_rd_o), 32'(exp_q[0].rd));
               chk({tag, "_data"}, reg_rd_o, exp_q[0].d);
            end
         end
         pushed   = wb_valid_i & wb_ready_o;
         popped   = stb_write_o & ack_write_i;
         gap_due  = popped;
         prev_stb = stb_write_o;
         @(posedge clk_i);
         #1;
         if (pushed) begin
            e = src_q.pop_front();
            if (e.rd != 5'd0) exp_q.push_back(e);
         end
         if (popped && exp_q.size() != 0) begin
            void'(exp_q.pop_front());
            n++;
         end
         done = (src_q.size() == 0) && (exp_q.size() == 0) && !stb_write_o;
      end
      wb_valid_i  = 1'b0;
      ack_write_i = 1'b0;
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_writes"}, 32'(n), 32'(nwr));
      step();
      step();
      chk({tag, "_empty"}, 32'(empty_o), 32'd1);
   endtask

   initial begin
      tbl[0]  = mk(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[1]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
      tbl[2]  = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd0, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0);
      tbl[3]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tbl[4]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[5]  = mk(1'b1, 5'd0, 32'h1234, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[6]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[7]  = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[8]  = mk(1'b1, 5'd7, 32'h11, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);
      tbl[9]  = mk(1'b1, 5'd7, 32'h22, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h11, 32'h0, 1'b0);
      tbl[10] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
      tbl[11] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h11, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
      tbl[12] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
      tbl[13] = mk(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0, 1'b1, 1'b1, 5'd7, 32'h22, 1'b1, 1'b0, 32'h22, 32'h0, 1'b0);
      tbl[14] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
      tbl[15] = mk(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1);

      step();
      step();
      chk("rst_ready", 32'(wb_ready_o), 32'd1);
      chk("rst_empty", 32'(empty_o), 32'd1);
      chk("rst_stb", 32'(stb_write_o), 32'd0);
      chk("rst_cyc", 32'(cyc_write_o), 32'd0);
      chk("rst_op_rd", 32'(op_rd_o), 32'd0);
      chk("rst_reg_rd", reg_rd_o, 32'd0);
      chk("rst_pending", 32'({pending_rs1_o, pending_rs2_o}), 32'd0);
      chk("rst_fwd1", fwd_rs1_o, 32'd0);
      chk("rst_fwd2", fwd_rs2_o, 32'd0);
      rst_i = 1'b0;

      for (int i = 0; i < 16; i++) begin
         wb_valid_i  = tbl[i].v;
         wb_rd_i     = tbl[i].rd;
         wb_data_i   = tbl[i].d;
         ack_write_i = tbl[i].ack;
         op_rs1_i    = tbl[i].rs1;
         op_rs2_i    = tbl[i].rs2;
         #1;
         chk($sformatf("v%0d_ready", i), 32'(wb_ready_o), 32'(tbl[i].rdy));
         chk($sformatf("v%0d_stb", i), 32'(stb_write_o), 32'(tbl[i].stb));
         chk($sformatf("v%0d_cyc", i), 32'(cyc_write_o), 32'(tbl[i].stb));
         if (tbl[i].stb) begin
            chk($sformatf("v%0d_op_rd", i), 32'(op_rd_o), 32'(tbl[i].ord));
            chk($sformatf("v%0d_reg_rd", i), reg_rd_o, tbl[i].odat);
         end
         chk($sformatf("v%0d_pend1", i), 32'(pending_rs1_o), 32'(tbl[i].p1));
         chk($sformatf("v%0d_pend2", i), 32'(pending_rs2_o), 32'(tbl[i].p2));
         chk($sformatf("v%0d_fwd1", i), fwd_rs1_o, fwd_req(tbl[i].f1));
         chk($sformatf("v%0d_fwd2", i), fwd_rs2_o, fwd_req(tbl[i].f2));
         chk($sformatf("v%0d_empty", i), 32'(empty_o), 32'(tbl[i].emp));
         step();
      end
      wb_valid_i  = 1'b0;
      ack_write_i = 1'b0;
      op_rs1_i    = 5'd0;
      op_rs2_i    = 5'd0;

      for (int i = 1; i <= 4; i++) begin
         wb_valid_i = 1'b1;
         wb_rd_i    = 5'(i);
         wb_data_i  = 32'h100 + 32'(i);
         #1;
         chk($sformatf("full_push%0d_ready", i), 32'(wb_ready_o), 32'd1);
         step();
         exp_q.push_back('{5'(i), 32'h100 + 32'(i)});
      end
      wb_rd_i   = 5'd5;
      wb_data_i = 32'h105;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk("full_ready_low", 32'(wb_ready_o), 32'd0);
         chk("full_stb_held", 32'(stb_write_o), 32'd1);
         chk("full_head_rd", 32'(op_rd_o), 32'd1);
         step();
      end
      src_q.push_back('{5'd5, 32'h105});
      run_sb("full", 60, 1'b0, 5);

      for (int i = 0; i < 3; i++) begin
         wb_valid_i = 1'b1;
         wb_rd_i    = 5'(9 + i);
         wb_data_i  = 32'h900 + 32'(i);
         step();
      end
      wb_valid_i = 1'b0;
      for (int c = 0; c < 5 && !stb_write_o; c++) step();
      chk("rst_mid_in_write", 32'(stb_write_o), 32'd1);
      #2;
      rst_i = 1'b1;
      #1;
      chk("rst_mid_stb", 32'(stb_write_o), 32'd0);
      chk("rst_mid_ready", 32'(wb_ready_o), 32'd1);
      chk("rst_mid_empty", 32'(empty_o), 32'd1);
      step();
      rst_i = 1'b0;
      ack_write_i = 1'b1;
      for (int c = 0; c < 6; c++) begin
         step();
         chk("rst_no_write", 32'(stb_write_o), 32'd0);
      end
      ack_write_i = 1'b0;
      exp_q.delete();
      src_q.push_back('{5'd12, 32'h4C});
      run_sb("after_rst", 20, 1'b0, 1);

      for (int i = 0; i < 16; i++) src_q.push_back('{5'((i % 31) + 1), 32'hC0DE0000 + 32'(i * 7)});
      run_sb("stream", 200, 1'b1, 16);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
